// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared types and helpers for the load/store bus port.
//   op_size_e   : access size encoding carried on the op input
//   lsu_state_e : control states of the bus port
//   size_mask() : byte-enable mask (one bit per byte) for an access size
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } op_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    function automatic logic [7:0] size_mask(input op_size_e sz);
        logic [7:0] m;
        case (sz)
            BYTE:    m = 8'h01;
            HALF:    m = 8'h03;
            WORD:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
// Combinational lane steering between the core and an XLEN-wide data bus.
// Ports:
//   i_op          access size (op_size_e encoding)
//   i_offset      byte lane offset of the access inside the bus word
//   i_is_write    store when 1; byte enables are zero for loads
//   i_is_unsigned zero-extend loaded data when 1, sign-extend when 0
//   i_wdata       store data in the low bits
//   i_rdata       raw bus read data
//   o_wstrb       byte enables for the bus request
//   o_wdata       store data replicated across every lane
//   o_rdata       loaded value, shifted down to bit 0 and extended
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                 i_op,
    input  logic [$clog2(XLEN/8)-1:0]  i_offset,
    input  logic                       i_is_write,
    input  logic                       i_is_unsigned,
    input  logic [XLEN-1:0]            i_wdata,
    input  logic [XLEN-1:0]            i_rdata,
    output logic [XLEN/8-1:0]          o_wstrb,
    output logic [XLEN-1:0]            o_wdata,
    output logic [XLEN-1:0]            o_rdata
);

    localparam int NB = XLEN / 8;
    localparam int IW = $clog2(XLEN);

    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_shifted;
    logic [IW-1:0]   w_msb;
    logic            w_sign;

    assign w_mask  = NB'(size_mask(op_size_e'(i_op)));
    assign o_wstrb = i_is_write ? (w_mask << i_offset) : '0;

    // Replicating the datum into every lane lets the slave pick it up from
    // whichever lane the strobes select, without a data shifter here.
    always_comb begin
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            case (op_size_e'(i_op))
                BYTE:    o_wdata[8*i +: 8] = i_wdata[7:0];
                HALF:    o_wdata[8*i +: 8] = i_wdata[8*(i%2) +: 8];
                WORD:    o_wdata[8*i +: 8] = i_wdata[8*(i%4) +: 8];
                default: o_wdata[8*i +: 8] = i_wdata[8*i +: 8];
            endcase
        end
    end

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Bits above the size's top bit take the extension value; a full-width
    // access has no bits above it, so is_unsigned has no effect there.
    always_comb begin
        w_msb = IW'(XLEN - 1);
        case (op_size_e'(i_op))
            BYTE:    w_msb = IW'(7);
            HALF:    w_msb = IW'(15);
            WORD:    w_msb = IW'(31);
            default: w_msb = IW'(XLEN - 1);
        endcase
        w_sign  = !i_is_unsigned && w_shifted[w_msb];
        o_rdata = '0;
        for (int b = 0; b < XLEN; b++) begin
            o_rdata[b] = (b <= int'(w_msb)) ? w_shifted[b] : w_sign;
        end
    end

endmodule

// File: rtl/lsu_bus_port.sv
// lsu_bus_port
// Load/store access unit between the execute stage and a valid/ready data
// bus. One operation at a time: size/alignment check, request, response
// wait with optional timeout, then lane-aligned extended result.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   available               op request, held with op fields until done
//   is_write, is_unsigned   store select, load zero-extend select
//   op, addr, in            access size, byte address, store data
//   out                     load result (0 for stores and faults)
//   busy, done              transaction in flight / result valid
//   op_fault, addr_fault    invalid size / misaligned address
//   access_fault, timeout   misalign, bus error or timeout / timeout cause
//   bus_req_*               request channel (valid/ready)
//   bus_rsp_*               response channel (valid, data, error)
module lsu_bus_port
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                available,
    input  logic                is_write,
    input  logic                is_unsigned,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     in,
    output logic [XLEN-1:0]     out,
    output logic                busy,
    output logic                done,
    output logic                op_fault,
    output logic                addr_fault,
    output logic                access_fault,
    output logic                timeout,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [XLEN-1:0]     bus_req_addr,
    output logic                bus_req_write,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_wstrb,
    input  logic                bus_rsp_valid,
    input  logic [XLEN-1:0]     bus_rsp_rdata,
    input  logic                bus_rsp_error
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    lsu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_out;
    logic               r_op_fault;
    logic               r_addr_fault;
    logic               r_access_fault;
    logic               r_timeout;
    logic [XLEN-1:0]    r_req_addr;
    logic               r_req_write;
    logic [XLEN-1:0]    r_req_wdata;
    logic [NB-1:0]      r_req_wstrb;

    logic               w_op_invalid;
    logic               w_misaligned;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_expired;
    logic [NB-1:0]      w_wstrb;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_rdata;

    // Op fields are held stable by the core until done, so the aligner can
    // work from the live inputs both when issuing and when the response lands.
    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .i_op          (op),
        .i_offset      (addr[OFFW-1:0]),
        .i_is_write    (is_write),
        .i_is_unsigned (is_unsigned),
        .i_wdata       (in),
        .i_rdata       (bus_rsp_rdata),
        .o_wstrb       (w_wstrb),
        .o_wdata       (w_wdata),
        .o_rdata       (w_rdata)
    );

    assign w_op_invalid = (op_size_e'(op) == DOUBLE) && (XLEN == 32);

    always_comb begin
        w_misaligned = 1'b0;
        case (op_size_e'(op))
            HALF:    w_misaligned = addr[0];
            WORD:    w_misaligned = |addr[1:0];
            DOUBLE:  w_misaligned = |addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // w_cnt_inc is the number of busy cycles including the current one.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_expired = (TIMEOUT != 0) && (w_cnt_inc >= CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_out          <= '0;
            r_op_fault     <= 1'b0;
            r_addr_fault   <= 1'b0;
            r_access_fault <= 1'b0;
            r_timeout      <= 1'b0;
            r_req_addr     <= '0;
            r_req_write    <= 1'b0;
            r_req_wdata    <= '0;
            r_req_wstrb    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (available) begin
                        r_out          <= '0;
                        r_timeout      <= 1'b0;
                        r_op_fault     <= w_op_invalid;
                        // An invalid size has no alignment rule to check.
                        r_addr_fault   <= !w_op_invalid && w_misaligned;
                        r_access_fault <= !w_op_invalid && w_misaligned;
                        if (w_op_invalid || w_misaligned) begin
                            r_state <= DONE;
                        end else begin
                            r_state     <= REQ;
                            r_cnt       <= '0;
                            r_req_addr  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                            r_req_write <= is_write;
                            r_req_wdata <= w_wdata;
                            r_req_wstrb <= w_wstrb;
                        end
                    end
                end
                REQ: begin
                    // An accepted handshake takes priority over expiry so a
                    // request the slave has taken is never abandoned here.
                    if (bus_req_ready) begin
                        r_state <= RSP;
                        r_cnt   <= w_cnt_inc;
                    end else if (w_expired) begin
                        r_state        <= DONE;
                        r_access_fault <= 1'b1;
                        r_timeout      <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RSP: begin
                    if (bus_rsp_valid) begin
                        r_state        <= DONE;
                        r_access_fault <= bus_rsp_error;
                        r_out          <= (bus_rsp_error || r_req_write) ? '0 : w_rdata;
                    end else if (w_expired) begin
                        r_state        <= DONE;
                        r_access_fault <= 1'b1;
                        r_timeout      <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    if (!available) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out           = r_out;
    assign busy          = (r_state == REQ) || (r_state == RSP);
    assign done          = (r_state == DONE);
    assign op_fault      = r_op_fault;
    assign addr_fault    = r_addr_fault;
    assign access_fault  = r_access_fault;
    assign timeout       = r_timeout;
    assign bus_req_valid = (r_state == REQ);
    assign bus_req_addr  = r_req_addr;
    assign bus_req_write = r_req_write;
    assign bus_req_wdata = r_req_wdata;
    assign bus_req_wstrb = r_req_wstrb;

endmodule

// File: tb/tb_lsu_bus_port.sv
// tb_lsu_bus_port
// Directed bench: a 32-bit instance with a short timeout (index 0) and a
// 64-bit instance with the default timeout (index 1).
module tb_lsu_bus_port;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        avail   = '0;
    logic [1:0]        is_wr   = '0;
    logic [1:0]        is_uns  = '0;
    logic [1:0]        req_rdy = '0;
    logic [1:0]        rsp_vld = '0;
    logic [1:0]        rsp_err = '0;
    logic [1:0][1:0]   opv     = '0;
    logic [1:0][63:0]  addr_v  = '0;
    logic [1:0][63:0]  in_v    = '0;
    logic [1:0][63:0]  rdata_v = '0;

    wire [31:0] out32, bra32, wd32;
    wire [3:0]  ws32;
    wire [63:0] out64, bra64, wd64;
    wire [7:0]  ws64;
    wire [1:0]  busy_v, done_v, opf_v, adf_v, acf_v, to_v, rqv_v, rqw_v;

    lsu_bus_port #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .available(avail[0]), .is_write(is_wr[0]),
        .is_unsigned(is_uns[0]), .op(opv[0]), .addr(addr_v[0][31:0]), .in(in_v[0][31:0]),
        .out(out32), .busy(busy_v[0]), .done(done_v[0]), .op_fault(opf_v[0]),
        .addr_fault(adf_v[0]), .access_fault(acf_v[0]), .timeout(to_v[0]),
        .bus_req_valid(rqv_v[0]), .bus_req_ready(req_rdy[0]), .bus_req_addr(bra32),
        .bus_req_write(rqw_v[0]), .bus_req_wdata(wd32), .bus_req_wstrb(ws32),
        .bus_rsp_valid(rsp_vld[0]), .bus_rsp_rdata(rdata_v[0][31:0]), .bus_rsp_error(rsp_err[0])
    );

    lsu_bus_port #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .available(avail[1]), .is_write(is_wr[1]),
        .is_unsigned(is_uns[1]), .op(opv[1]), .addr(addr_v[1]), .in(in_v[1]),
        .out(out64), .busy(busy_v[1]), .done(done_v[1]), .op_fault(opf_v[1]),
        .addr_fault(adf_v[1]), .access_fault(acf_v[1]), .timeout(to_v[1]),
        .bus_req_valid(rqv_v[1]), .bus_req_ready(req_rdy[1]), .bus_req_addr(bra64),
        .bus_req_write(rqw_v[1]), .bus_req_wdata(wd64), .bus_req_wstrb(ws64),
        .bus_rsp_valid(rsp_vld[1]), .bus_rsp_rdata(rdata_v[1]), .bus_rsp_error(rsp_err[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] cap_addr, cap_wdata, cap_out;
    logic [7:0]  cap_strb;
    logic        cap_write;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] get_out(input int sel);
        return (sel == 1) ? out64 : {32'h0, out32};
    endfunction

    // Full load/store with immediate acceptance and a response the cycle
    // after; leaves the port in DONE with available still high.
    task automatic xact(input int sel, input logic [1:0] op, input logic [63:0] a,
                        input logic w, input logic u, input logic [63:0] d,
                        input logic [63:0] rd, input logic err);
        opv[sel] = op; addr_v[sel] = a; is_wr[sel] = w; is_uns[sel] = u;
        in_v[sel] = d; avail[sel] = 1'b1;
        tick;
        check("req_valid", rqv_v[sel], 1);
        check("busy_req", busy_v[sel], 1);
        cap_addr  = (sel == 1) ? bra64 : {32'h0, bra32};
        cap_wdata = (sel == 1) ? wd64 : {32'h0, wd32};
        cap_strb  = (sel == 1) ? ws64 : {4'h0, ws32};
        cap_write = rqw_v[sel];
        req_rdy[sel] = 1'b1;
        tick;
        req_rdy[sel] = 1'b0;
        check("req_dropped", rqv_v[sel], 0);
        check("done_early", done_v[sel], 0);
        rsp_vld[sel] = 1'b1; rdata_v[sel] = rd; rsp_err[sel] = err;
        tick;
        rsp_vld[sel] = 1'b0; rsp_err[sel] = 1'b0;
        check("done_latency", done_v[sel], 1);
        check("busy_done", busy_v[sel], 0);
        cap_out = get_out(sel);
    endtask

    task automatic finish_op(input int sel);
        avail[sel] = 1'b0;
        tick;
        check("back_to_idle", done_v[sel], 0);
    endtask

    initial begin
        int nbusy;

        repeat (3) tick;
        // Reset state, both widths
        check("rst_out32", out32, 0);
        check("rst_out64", out64, 0);
        check("rst_busy", busy_v, 0);
        check("rst_done", done_v, 0);
        check("rst_faults", {opf_v, adf_v, acf_v, to_v}, 0);
        check("rst_req_valid", rqv_v, 0);
        check("rst_req_write", rqw_v, 0);
        check("rst_req_addr", {bra32, bra64}, 0);
        check("rst_req_wdata", {wd32, wd64}, 0);
        check("rst_req_wstrb", {ws32, ws64}, 0);
        reset = 1'b0;
        tick;

        // Aligned word load
        xact(0, 2'b10, 64'h104, 0, 0, 0, 64'hDEADBEEF, 0);
        check("wl_out", cap_out, 64'hDEADBEEF);
        check("wl_addr", cap_addr, 64'h104);
        check("wl_wstrb", cap_strb, 0);
        check("wl_faults", {opf_v[0], adf_v[0], acf_v[0], to_v[0]}, 0);
        finish_op(0);

        // Byte load, signed then unsigned
        xact(0, 2'b00, 64'h103, 0, 0, 0, 64'h80FFFFFF, 0);
        check("lb_signed", cap_out, 64'hFFFFFF80);
        check("lb_addr", cap_addr, 64'h100);
        finish_op(0);
        xact(0, 2'b00, 64'h103, 0, 1, 0, 64'h80FFFFFF, 0);
        check("lb_unsigned", cap_out, 64'h00000080);
        finish_op(0);

        // Half store
        xact(0, 2'b01, 64'h102, 1, 0, 64'h1234, 0, 0);
        check("sh_wstrb", cap_strb, 8'hC);
        check("sh_wdata", cap_wdata, 64'h12341234);
        check("sh_addr", cap_addr, 64'h100);
        check("sh_write", cap_write, 1);
        check("sh_out", cap_out, 0);
        finish_op(0);

        // Misaligned word: fault path, no bus activity
        opv[0] = 2'b10; addr_v[0] = 64'h101; is_wr[0] = 0; avail[0] = 1'b1;
        tick;
        check("mis_done", done_v[0], 1);
        check("mis_addr_fault", adf_v[0], 1);
        check("mis_access_fault", acf_v[0], 1);
        check("mis_op_fault", opf_v[0], 0);
        check("mis_busy", busy_v[0], 0);
        check("mis_req_valid", rqv_v[0], 0);
        finish_op(0);

        // Invalid op on 32-bit: address check skipped
        opv[0] = 2'b11; addr_v[0] = 64'h101; avail[0] = 1'b1;
        tick;
        check("inv_done", done_v[0], 1);
        check("inv_op_fault", opf_v[0], 1);
        check("inv_addr_fault", adf_v[0], 0);
        check("inv_access_fault", acf_v[0], 0);
        check("inv_req_valid", rqv_v[0], 0);
        finish_op(0);

        // Timeout: accepted, never answered
        opv[0] = 2'b10; addr_v[0] = 64'h200; is_uns[0] = 0; avail[0] = 1'b1;
        req_rdy[0] = 1'b1;
        nbusy = 0;
        for (int k = 0; k < 20 && !done_v[0]; k++) begin
            tick;
            if (busy_v[0]) nbusy++;
        end
        req_rdy[0] = 1'b0;
        check("to_done", done_v[0], 1);
        check("to_busy_cycles", nbusy, 4);
        check("to_access_fault", acf_v[0], 1);
        check("to_timeout", to_v[0], 1);
        check("to_out", out32, 0);
        rsp_vld[0] = 1'b1; rdata_v[0] = 64'hFFFF;
        tick;
        check("late_rsp_out", out32, 0);
        avail[0] = 1'b0;
        tick;
        tick;
        check("late_rsp_done", done_v[0], 0);
        check("late_rsp_busy", busy_v[0], 0);
        rsp_vld[0] = 1'b0;
        xact(0, 2'b10, 64'h204, 0, 0, 0, 64'h11223344, 0);
        check("post_to_out", cap_out, 64'h11223344);
        check("post_to_flags", {acf_v[0], to_v[0]}, 0);
        finish_op(0);

        // 64-bit doubleword load
        xact(1, 2'b11, 64'h8, 0, 1, 0, 64'h0123456789ABCDEF, 0);
        check("ld_out", cap_out, 64'h0123456789ABCDEF);
        check("ld_addr", cap_addr, 64'h8);
        check("ld_faults", {opf_v[1], adf_v[1], acf_v[1]}, 0);
        finish_op(1);

        // 64-bit doubleword load with bus error
        xact(1, 2'b11, 64'h8, 0, 0, 0, 64'h0123456789ABCDEF, 1);
        check("err_access_fault", acf_v[1], 1);
        check("err_out", cap_out, 0);
        check("err_timeout", to_v[1], 0);
        finish_op(1);

        // 64-bit signed byte from the top lane
        xact(1, 2'b00, 64'hF, 0, 0, 0, 64'h8000000000000000, 0);
        check("lb64_signed", cap_out, 64'hFFFFFFFFFFFFFF80);
        finish_op(1);

        // 64-bit word store in the upper half
        xact(1, 2'b10, 64'h14, 1, 0, 64'hCAFEF00D, 0, 0);
        check("sw64_wstrb", cap_strb, 8'hF0);
        check("sw64_wdata", cap_wdata, 64'hCAFEF00DCAFEF00D);
        check("sw64_addr", cap_addr, 64'h10);
        finish_op(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/lsu_bus_port.md
# lsu_bus_port

Parametrised load/store access unit sitting between the execute stage and the data-memory bus. It accepts one memory operation at a time from the core, checks op size and alignment, and drives a valid/ready request channel. It then waits for the response, which carries an error flag, and returns the lane-aligned, sign- or zero-extended result with fault flags. It adds XLEN generalisation, doubleword support, byte-strobe writes and a response timeout.

## Interface
- XLEN, 32: data/address width; 32 or 64 only.
- TIMEOUT, 255: max cycles from request issue to response before an access fault; 0 disables the timeout.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- available  in  1  op request; held high, with all op inputs stable, until `done` is seen.
- is_write  in  1  1 = store, 0 = load.
- is_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- op  in  2  size: 00 byte, 01 half, 10 word, 11 double (valid only when XLEN=64).
- addr  in  XLEN  byte address.
- in  in  XLEN  store data, in the low bits.
- out  out  XLEN  load result; 0 for stores and faults.
- busy  out  1  bus transaction in flight.
- done  out  1  result and fault flags are valid.
- op_fault  out  1  invalid op.
- addr_fault  out  1  misaligned address.
- access_fault  out  1  misaligned address, bus error, or timeout.
- timeout  out  1  access fault was caused by the timeout.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_req_addr  out  XLEN  addr with the low log2(XLEN/8) bits cleared.
- bus_req_write  out  1  store request.
- bus_req_wdata  out  XLEN  store data replicated across all lanes.
- bus_req_wstrb  out  XLEN/8  byte enables.
- bus_rsp_valid  in  1  response valid.
- bus_rsp_rdata  in  XLEN  read data.
- bus_rsp_error  in  1  bus error.

## Operation
- **States:**
  - IDLE: if `available`, decode the op.
    - Invalid op or misaligned address: go to DONE with faults set; no bus request is issued.
    - Otherwise: go to REQ.
  - REQ: drive `bus_req_valid`. On `bus_req_ready`, go to RSP.
  - RSP: on `bus_rsp_valid`, capture the response and go to DONE.
  - DONE: hold `done` and all results. Return to IDLE when `available` is 0.
- **Misaligned:** half with addr[0]=1; word with addr[1:0]≠0; double with addr[2:0]≠0. Misalignment sets both `addr_fault` and `access_fault`.
- **Invalid op:** op=11 when XLEN=32. It sets `op_fault` only; the address check is skipped for it.
- **wstrb:** size mask (1/3/F/FF) shifted left by the lane offset addr[log2(XLEN/8)-1:0]; all zeros on loads.
- **Load result:** bus_rsp_rdata shifted right by 8×offset, truncated to the op size, then extended per `is_unsigned`. For doubleword, `is_unsigned` has no effect.
- **Bus error:** `bus_rsp_error`=1 sets `access_fault` and forces `out` to 0.
- **Timeout counter:** cleared on entry to REQ; increments each cycle in REQ or RSP. Reaching TIMEOUT goes to DONE with `access_fault`=1 and `timeout`=1; `bus_req_valid` is dropped.
- **Ignored inputs:**
  - `bus_rsp_valid` is ignored outside RSP, including late responses after a timeout.
  - `available` is ignored outside IDLE and DONE.

## Timing
- **Reset values:** state IDLE. Every output is 0: out, busy, done, all faults, timeout, and all bus_req_* outputs.
- **Reset mid-operation:** next cycle is IDLE with `bus_req_valid`=0. Any later response is ignored.
- **busy:** 1 exactly in REQ and RSP.
- **done:** 1 exactly in DONE. Fault flags and `out` are valid only while `done`=1.
- **Fault path:** `available` sampled at cycle t → `done` and faults at t+1; `busy` never rises.
- **Minimum load latency:** `available` at t → `bus_req_valid` at t+1, `bus_req_ready` at t+1 → `bus_rsp_valid` at t+2 → `done` at t+3.
- **Response timing:** the response is taken no earlier than the cycle after acceptance.
- **Timeout vs. response:** if the timeout and `bus_rsp_valid` coincide, the response wins.
- **Request stability:** the request fields stay stable while `bus_req_valid`=1 and `bus_req_ready`=0.
- **Back-to-back ops:** `available` must drop for at least one cycle between operations.

## Structure
- **Shared package lsu_pkg:**
  - op_size_e enum (BYTE, HALF, WORD, DOUBLE).
  - lsu_state_e (IDLE, REQ, RSP, DONE).
  - Function size_mask(op) returning the byte-count mask.
- **Sub-module lsu_lane_align** (combinational, parametrised by XLEN):
  - Builds `bus_req_wstrb` and the replicated `bus_req_wdata`.
  - Extracts and extends read data.
- **Top module:** state machine, timeout counter, fault registers.

## Test plan
- **Word load, aligned (XLEN=32):** addr 0x104, ready immediate, rdata 0xDEADBEEF one cycle later → `done` at t+3, `out`=0xDEADBEEF, no faults.
- **Byte load, signed and unsigned:** addr 0x103, rdata 0x80FFFFFF.
  - `is_unsigned`=0 → `out`=0xFFFFFF80.
  - `is_unsigned`=1 → `out`=0x00000080.
- **Half store:** addr 0x102, `in`=0x1234 → wstrb=1100, wdata=0x12341234, bus_req_addr=0x100.
- **Misaligned word and invalid op:**
  - addr 0x101 → `done` at t+1 with `addr_fault`=`access_fault`=1, `busy`=0, no `bus_req_valid`.
  - op=11 (XLEN=32) → `op_fault`=1.
- **Timeout:** TIMEOUT=4, no response → `access_fault`=1 and `timeout`=1 after 4 busy cycles. A late `bus_rsp_valid` is ignored; the next op completes normally.
- **XLEN=64 doubleword load and bus error:**
  - addr 0x8, rdata 0x0123456789ABCDEF → `out` equals rdata.
  - Repeat with `bus_rsp_error`=1 → `access_fault`=1, `out`=0.
